// File: rtl/pdh_gpio_pkg.sv
// pdh_gpio_pkg
// Shared definitions for the PS GPIO command bridge. Holds the opcode and FSM
// state enums plus the bit layout of the 32-bit command and response words,
// so the bridge and anything that decodes its traffic agree on one layout.
package pdh_gpio_pkg;

  // Command word layout (PS -> PL)
  localparam int STROBE_BIT = 31;
  localparam int OPC_LSB    = 28;
  localparam int OPC_W      = 3;
  localparam int ADDR_LSB   = 24;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 24;

  // Response word layout (PL -> PS); result occupies [DATA_W-1:0]
  localparam int ACK_BIT       = 31;
  localparam int ERR_BIT       = 30;
  localparam int RESP_ADDR_LSB = 24;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP     = 3'd0,
    OP_WRITE   = 3'd1,
    OP_READ    = 3'd2,
    OP_SET     = 3'd3,
    OP_CLR     = 3'd4,
    OP_PULSE   = 3'd5,
    OP_STATUS  = 3'd6,
    OP_ILLEGAL = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/pdh_sync_bus.sv
// pdh_sync_bus
// Multi-flop synchroniser for a bus that crosses into the clk domain.
// The bus is only trusted once the sender has held it stable for longer than
// the chain depth, so per-bit skew is tolerated by the protocol above it.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears every stage
//   d    - asynchronous input bus
//   q    - synchronised bus (last stage)
module pdh_sync_bus #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the input through the chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pdh_gpio_cmd_bridge.sv
// pdh_gpio_cmd_bridge
// Toggle-handshaked command engine between the PS GPIO pair and the pdh_core
// register file. The PS flips bit 31 of the command word to issue a command;
// the bridge flips bit 31 of the response word once it has executed it.
// Ports:
//   clk, rst     - pdh_clk and synchronous active-high reset
//   gpio_in_i    - command word from PS (asynchronous)
//   gpio_out_o   - response word to PS (holds between commands)
//   regs_o       - flat register file, reg n at [n*REG_WIDTH +: REG_WIDTH]
//   pulse_o      - one-cycle strobe per register for PULSE commands
//   status_i     - live status words returned by STATUS commands
//   busy_o       - high while a command is in flight
//   cmd_count_o  - count of completed commands, wraps at 16 bits
module pdh_gpio_cmd_bridge
  import pdh_gpio_pkg::*;
#(
  parameter int GPIO_IN_WIDTH  = 32,
  parameter int GPIO_OUT_WIDTH = 32,
  parameter int NUM_REGS       = 8,
  parameter int REG_WIDTH      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GPIO_IN_WIDTH-1:0]      gpio_in_i,
  output logic [GPIO_OUT_WIDTH-1:0]     gpio_out_o,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]           pulse_o,
  input  logic [NUM_REGS*REG_WIDTH-1:0] status_i,
  output logic                          busy_o,
  output logic [15:0]                   cmd_count_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [GPIO_IN_WIDTH-1:0]  sync_word;
  state_e                    state_q, state_d;
  logic                      ack_q, strobe_q, busy_q, err_q;
  opcode_e                   opc_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [DATA_W-1:0]         data_q, result_q;
  logic [REG_WIDTH-1:0]      regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]       pulse_q;
  logic [GPIO_OUT_WIDTH-1:0] gpio_out_q, resp_word;
  logic [15:0]               cmd_count_q;

  logic [IDX_W-1:0]          idx;
  logic                      addr_ok;
  logic [REG_WIDTH-1:0]      cur_reg, reg_new, exec_res;
  logic                      reg_wr, pulse_hit, exec_err;
  int                        status_base;
  logic                      data_unused;

  pdh_sync_bus #(
    .WIDTH  (GPIO_IN_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in_i),
    .q   (sync_word)
  );

  // Out-of-range addresses are rejected before any indexing takes effect.
  assign idx         = addr_q[IDX_W-1:0];
  assign addr_ok     = ({1'b0, addr_q} < 5'(NUM_REGS));
  // Data bits above REG_WIDTH are ignored by design.
  assign data_unused = ^data_q;

  // Level compare of strobe against ack: toggles that arrive while busy are
  // resolved once back in IDLE, so a double toggle simply cancels out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sync_word[STROBE_BIT] != ack_q) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Opcode execution against the captured command; write opcodes report the
  // post-update register value as their result.
  always_comb begin
    cur_reg     = regs_q[idx];
    status_base = int'(idx) * REG_WIDTH;
    reg_new     = cur_reg;
    reg_wr      = 1'b0;
    pulse_hit   = 1'b0;
    exec_err    = 1'b0;
    exec_res    = '0;
    if (opc_q == OP_ILLEGAL || !addr_ok) begin
      exec_err = 1'b1;
    end else begin
      case (opc_q)
        OP_WRITE: begin
          reg_new  = data_q[REG_WIDTH-1:0];
          reg_wr   = 1'b1;
          exec_res = reg_new;
        end
        OP_READ:  exec_res = cur_reg;
        OP_SET: begin
          reg_new  = cur_reg | data_q[REG_WIDTH-1:0];
          reg_wr   = 1'b1;
          exec_res = reg_new;
        end
        OP_CLR: begin
          reg_new  = cur_reg & ~data_q[REG_WIDTH-1:0];
          reg_wr   = 1'b1;
          exec_res = reg_new;
        end
        OP_PULSE:  pulse_hit = 1'b1;
        OP_STATUS: exec_res  = status_i[status_base +: REG_WIDTH];
        default:   ;
      endcase
    end
  end

  always_comb begin
    resp_word                            = '0;
    resp_word[ACK_BIT]                   = strobe_q;
    resp_word[ERR_BIT]                   = err_q;
    resp_word[RESP_ADDR_LSB +: ADDR_W]   = addr_q;
    resp_word[DATA_W-1:0]                = result_q;
  end

  // Each state's action happens on the edge that enters the next state:
  // capture while IDLE, apply on DECODE->EXEC, respond on EXEC->RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      strobe_q    <= 1'b0;
      opc_q       <= OP_NOP;
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      result_q    <= '0;
      pulse_q     <= '0;
      gpio_out_q  <= '0;
      cmd_count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL[i*REG_WIDTH +: REG_WIDTH];
      end
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      pulse_q <= '0;
      if (state_q == ST_IDLE) begin
        strobe_q <= sync_word[STROBE_BIT];
        opc_q    <= opcode_e'(sync_word[OPC_LSB +: OPC_W]);
        addr_q   <= sync_word[ADDR_LSB +: ADDR_W];
        data_q   <= sync_word[DATA_W-1:0];
      end
      if (state_q == ST_DECODE) begin
        if (reg_wr)    regs_q[idx]  <= reg_new;
        if (pulse_hit) pulse_q[idx] <= 1'b1;
        err_q    <= exec_err;
        result_q <= DATA_W'(exec_res);
      end
      if (state_q == ST_EXEC) begin
        gpio_out_q  <= resp_word;
        ack_q       <= strobe_q;
        cmd_count_q <= cmd_count_q + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
  end

  assign gpio_out_o  = gpio_out_q;
  assign pulse_o     = pulse_q;
  assign busy_o      = busy_q;
  assign cmd_count_o = cmd_count_q;

endmodule

// File: tb/tb_pdh_gpio_cmd_bridge.sv
// tb_pdh_gpio_cmd_bridge
// Directed bench for the GPIO command bridge. Each command computes its
// expected response, register image, counter and pulse mask from a small
// register-file model and queues it; the matching DUT response is popped and
// compared once the ack toggle appears.
module tb_pdh_gpio_cmd_bridge;

  localparam int NR = 8;
  localparam int RW = 16;
  localparam int FW = NR * RW;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   gpio_in;
  logic [31:0]   gpio_out;
  logic [FW-1:0] regs;
  logic [NR-1:0] pulse;
  logic [FW-1:0] status;
  logic          busy;
  logic [15:0]   cmd_count;

  pdh_gpio_cmd_bridge #(
    .GPIO_IN_WIDTH  (32),
    .GPIO_OUT_WIDTH (32),
    .NUM_REGS       (NR),
    .REG_WIDTH      (RW),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_in_i   (gpio_in),
    .gpio_out_o  (gpio_out),
    .regs_o      (regs),
    .pulse_o     (pulse),
    .status_i    (status),
    .busy_o      (busy),
    .cmd_count_o (cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [31:0]   resp;
    logic [FW-1:0] prev_regs;
    logic [FW-1:0] regs;
    logic [15:0]   count;
    logic [NR-1:0] pulse;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            passes = 0;
  logic [RW-1:0] m_regs [NR];
  logic [15:0]   m_count;
  logic          m_strobe;
  logic [31:0]   m_last_resp;

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*RW +: RW] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_count     = '0;
    m_strobe    = 1'b0;
    m_last_resp = '0;
  endtask

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one command word at a falling edge and queue what it should produce.
  task automatic applyStimulus(input logic [2:0] opc, input logic [3:0] addr,
                               input logic [23:0] data, input string tag);
    exp_t          e;
    logic [RW-1:0] res;
    logic          err;
    @(negedge clk);
    e.tag       = tag;
    e.prev_regs = model_flat();
    e.pulse     = '0;
    res         = '0;
    err         = (opc == 3'd7) || (addr >= 4'(NR));
    if (!err) begin
      case (opc)
        3'd1: begin m_regs[addr[2:0]] = data[RW-1:0]; res = m_regs[addr[2:0]]; end
        3'd2: res = m_regs[addr[2:0]];
        3'd3: begin m_regs[addr[2:0]] = m_regs[addr[2:0]] | data[RW-1:0]; res = m_regs[addr[2:0]]; end
        3'd4: begin m_regs[addr[2:0]] = m_regs[addr[2:0]] & ~data[RW-1:0]; res = m_regs[addr[2:0]]; end
        3'd5: e.pulse[addr[2:0]] = 1'b1;
        3'd6: res = status[int'(addr)*RW +: RW];
        default: ;
      endcase
    end
    m_strobe    = ~m_strobe;
    m_count     = m_count + 16'd1;
    e.resp      = {m_strobe, err, 2'b00, addr, 8'h00, res};
    e.regs      = model_flat();
    e.count     = m_count;
    m_last_resp = e.resp;
    sb.push_back(e);
    gpio_in = {m_strobe, opc, addr, data};
  endtask

  // Wait (bounded) for the ack toggle, then compare against the queued entry.
  // With glitch set, the strobe is flipped and restored while the DUT is busy.
  task automatic checkOutput(input bit glitch);
    exp_t          e;
    int            cyc  = 0;
    int            pcyc = 0;
    logic [NR-1:0] pseen = '0;
    logic [FW-1:0] r3 = '0;
    logic [FW-1:0] r4 = '0;
    logic          b4 = 1'b0;
    e = sb.pop_front();
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pulse !== '0) begin
        pcyc++;
        pseen |= pulse;
      end
      if (cyc == 3) r3 = regs;
      if (cyc == 4) begin
        r4 = regs;
        b4 = busy;
      end
      if (glitch && (cyc == 3 || cyc == 4)) gpio_in[31] = ~gpio_in[31];
      if (gpio_out[31] === e.resp[31]) break;
    end
    check({e.tag, " ack_latency"}, FW'(cyc), FW'(5));
    check({e.tag, " resp"}, FW'(gpio_out), FW'(e.resp));
    check({e.tag, " regs_before"}, r3, e.prev_regs);
    check({e.tag, " regs_after"}, r4, e.regs);
    check({e.tag, " busy_mid"}, FW'(b4), FW'(1));
    check({e.tag, " count"}, FW'(cmd_count), FW'(e.count));
    check({e.tag, " pulse_mask"}, FW'(pseen), FW'(e.pulse));
    check({e.tag, " pulse_cycles"}, FW'(pcyc), FW'((e.pulse != '0) ? 1 : 0));
    @(posedge clk);
    #1;
    check({e.tag, " busy_done"}, FW'(busy), FW'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [FW-1:0] mid_exp;
    rst     = 1'b1;
    gpio_in = '0;
    for (int k = 0; k < NR; k++) status[k*RW +: RW] = 16'hA000 + 16'(k);
    status[2*RW +: RW] = 16'h1234;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset regs", regs, '0);
    check("reset gpio_out", FW'(gpio_out), FW'(0));
    check("reset busy", FW'(busy), FW'(0));
    check("reset count", FW'(cmd_count), FW'(0));
    check("reset pulse", FW'(pulse), FW'(0));
    rst = 1'b0;

    applyStimulus(3'd1, 4'd3, 24'h00BEEF, "write3");     checkOutput(1'b0);
    check("write3 resp_word", FW'(gpio_out), FW'(32'h8300BEEF));
    applyStimulus(3'd3, 4'd3, 24'h000010, "set3");       checkOutput(1'b0);
    applyStimulus(3'd4, 4'd3, 24'h00000F, "clr3");       checkOutput(1'b0);
    applyStimulus(3'd2, 4'd3, 24'h000000, "read3");      checkOutput(1'b0);
    check("read3 resp_word", FW'(gpio_out), FW'(32'h0300BEF0));
    applyStimulus(3'd1, 4'd6, 24'hFF5A5A, "write6_hi");  checkOutput(1'b0);
    applyStimulus(3'd5, 4'd5, 24'h000000, "pulse5");     checkOutput(1'b0);
    applyStimulus(3'd6, 4'd2, 24'h000000, "status2");    checkOutput(1'b0);
    applyStimulus(3'd1, 4'd9, 24'h00DEAD, "bad_addr");   checkOutput(1'b0);
    applyStimulus(3'd7, 4'd1, 24'h00FFFF, "illegal");    checkOutput(1'b0);
    applyStimulus(3'd0, 4'd4, 24'h001234, "nop");        checkOutput(1'b0);

    // Double toggle while busy must not start a second command.
    applyStimulus(3'd1, 4'd1, 24'h001111, "glitch1");    checkOutput(1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("glitch no_extra_count", FW'(cmd_count), FW'(m_count));
    check("glitch idle", FW'(busy), FW'(0));
    check("glitch out_held", FW'(gpio_out), FW'(m_last_resp));
    check("glitch regs", regs, model_flat());

    // Reset while the WRITE is in EXEC: no ack, everything back to reset.
    @(negedge clk);
    gpio_in = {~m_strobe, 3'd1, 4'd2, 24'h007777};
    repeat (4) @(posedge clk);
    #1;
    mid_exp = model_flat();
    mid_exp[2*RW +: RW] = 16'h7777;
    check("exec regs_updated", regs, mid_exp);
    check("exec busy", FW'(busy), FW'(1));
    @(negedge clk);
    rst     = 1'b1;
    gpio_in = '0;
    @(posedge clk);
    #1;
    model_reset();
    check("midreset regs", regs, model_flat());
    check("midreset gpio_out", FW'(gpio_out), FW'(0));
    check("midreset count", FW'(cmd_count), FW'(0));
    check("midreset busy", FW'(busy), FW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("postreset no_cmd", FW'(cmd_count), FW'(0));

    // Counter wrap from a preloaded 0xFFFF.
    @(negedge clk);
    force dut.cmd_count_q = 16'hFFFF;
    #1;
    release dut.cmd_count_q;
    m_count = 16'hFFFF;
    applyStimulus(3'd1, 4'd0, 24'h00ABCD, "wrap");       checkOutput(1'b0);
    check("wrap count_zero", FW'(cmd_count), FW'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pdh_gpio_cmd_bridge.md
Name: pdh_gpio_cmd_bridge

Overview:
Parametrised command/response engine between the PS 32-bit GPIO pair (axi_from_ps / axi_to_ps) and the pdh_core control plane.
It replaces raw bit-mapped GPIO with a toggle-handshaked protocol that drives a register file of NUM_REGS control words. It supports write, read, bit set/clear, one-shot pulses and status readback.
It sits inside pdh_core on the pdh_clk domain and is the single owner of axi_to_ps.

Parameters:
GPIO_IN_WIDTH, 32, width of PS->PL word; fixed field layout requires exactly 32.
GPIO_OUT_WIDTH, 32, width of PL->PS word; must be 32.
NUM_REGS, 8, number of control/status registers; legal range 2..16.
REG_WIDTH, 16, bits per register; legal range 1..24.
SYNC_STAGES, 2, flop stages on gpio_in_i; legal range 2..4.
RESET_VAL, '0, NUM_REGS*REG_WIDTH flat reset image of the register file.

Ports:
clk  in  1  pdh_clk, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
gpio_in_i  in  32  command word from PS (asynchronous to clk).
gpio_out_o  out  32  response word to PS.
regs_o  out  NUM_REGS*REG_WIDTH  flat register file; reg n at [n*REG_WIDTH +: REG_WIDTH].
pulse_o  out  NUM_REGS  one-cycle strobe per register on PULSE.
status_i  in  NUM_REGS*REG_WIDTH  live status words for STATUS reads.
busy_o  out  1  high outside IDLE.
cmd_count_o  out  16  completed-command counter.

Behaviour:
- Command fields:
  - [31] strobe toggle.
  - [30:28] opcode.
  - [27:24] addr.
  - [23:0] data; low REG_WIDTH bits are used, the rest are ignored.
- Response fields:
  - [31] ack toggle.
  - [30] error.
  - [29:28] = 0.
  - [27:24] echoed addr.
  - [23:0] result, zero-extended from REG_WIDTH.
- Opcodes:
  - 0 NOP.
  - 1 WRITE: reg = data.
  - 2 READ: result = reg.
  - 3 SET: reg |= data.
  - 4 CLR: reg &= ~data.
  - 5 PULSE: pulse_o[addr] high for exactly one cycle; reg unchanged.
  - 6 STATUS: result = status_i[addr].
  - 7 illegal.
- Write opcodes (WRITE/SET/CLR) return the post-update reg value as result.
- gpio_in_i passes through SYNC_STAGES flops; all decisions use the synchronised word.
- FSM states IDLE, DECODE, EXEC, RESP:
  - IDLE: if sync strobe != ack_q, go to DECODE; else stay.
  - DECODE: capture opcode/addr/data from the sync word. The PS must hold the word stable for at least SYNC_STAGES+3 cycles. Always go to EXEC.
  - EXEC: apply the opcode; regs_o and pulse_o change on this edge. Always go to RESP.
  - RESP: drive gpio_out_o, set ack_q = captured strobe, increment cmd_count_o (wraps 0xFFFF->0). Go to IDLE.
- Latency: regs_o updates SYNC_STAGES+2 cycles after gpio_in_i changes. The ack toggle appears SYNC_STAGES+3 cycles after the change.
- Error case (addr >= NUM_REGS, or opcode 7):
  - No reg or pulse change.
  - error=1, result=0.
  - Still acked and still counted.
- NOP: error=0, result=0, acked.
- A strobe change while busy is not sampled. On return to IDLE the level compare applies, so two toggles during busy cancel and one toggle starts a new command.
- gpio_out_o holds its last value between commands. The error bit reflects only the most recent command.
- Reset values: regs_o=RESET_VAL, pulse_o=0, gpio_out_o=0, ack_q=0, busy_o=0, cmd_count_o=0, FSM=IDLE, sync chain=0.
- Reset mid-command aborts with no ack. After reset, a PS strobe left at 1 is treated as a new command, so the PS must clear bit 31 before releasing or re-issuing.
- busy_o is registered and high in DECODE, EXEC and RESP.

Decomposition:
- pdh_gpio_pkg holds:
  - opcode enum (OP_NOP..OP_ILLEGAL);
  - state enum;
  - field position/width localparams (STROBE_BIT, OPC_LSB, ADDR_LSB, DATA_W=24);
  - response bit positions.
- One sub-module, pdh_sync_bus: a parametrised WIDTH x SYNC_STAGES flop chain with synchronous reset.

Test Plan:
- Reset, then WRITE addr 3 data 0x00BEEF with toggle=1 -> regs_o[3]=0xBEEF at cycle 4; gpio_out_o=0x8300BEEF at cycle 5; cmd_count_o=1.
- SET addr 3 data 0x0010, then CLR addr 3 data 0x000F (toggles 0, 1) -> regs_o[3]=0xBEFF then 0xBEF0; READ addr 3 returns result 0xBEF0 with error=0.
- PULSE addr 5 -> pulse_o=0x20 for exactly one cycle; regs_o unchanged; ack toggles.
- status_i[2]=0x1234, STATUS addr 2 -> result 0x1234 in gpio_out_o.
- WRITE addr 9 (NUM_REGS=8), and separately opcode 7 -> error=1, result=0, no reg change, cmd_count_o increments both times.
- Two toggles while busy -> no extra command; assert rst during EXEC -> regs_o=RESET_VAL, gpio_out_o=0; counter preloaded to 0xFFFF wraps to 0 on the next command.
